nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

- Sequential wide adder that performs a WIDTH-bit addition one nibble per cycle through a single instance of the team's 4-bit ripple adder, `ripple_adder_4`.
- It drives that adder's A/B/Cin, consumes its Sum/Cout, and carries Cout between cycles.
- Operands arrive over a valid/ready handshake; the result leaves over a valid/ready handshake.
- Sits between the operand source and the result consumer wherever a wide add is needed without a wide combinational carry chain.

## Interface
Parameters:
- WIDTH, 16, operand/result width; multiple of 4, ≥4. NIB = WIDTH/4 (derived, not overridable).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to nibble 0.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  registered result, equal to (a+b+cin) mod 2^WIDTH.
- cout  output  1  carry out of MSB nibble.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- in_ready = (state==IDLE). out_valid = (state==DONE). Both decoded from registered state only.
- IDLE:
  - On in_valid && in_ready, latch a, b into operand regs, latch cin into carry reg, set idx=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - Adder inputs are a_reg[4*idx+:4], b_reg[4*idx+:4] and carry reg.
  - Each edge writes adder Sum into shadow_sum[4*idx+:4] and writes adder Cout into the carry reg.
  - While idx<NIB-1: increment idx, stay in RUN.
  - When idx==NIB-1: copy the completed shadow_sum (including this nibble) into sum, copy the final Cout into cout, go to DONE.
- DONE:
  - sum and cout are held stable.
  - On out_valid && out_ready, go to IDLE.
  - in_valid is ignored; no capture occurs.
- sum/cout change only on RUN→DONE; they keep the last result through IDLE and the next RUN.
- idx width is clog2(NIB), minimum 1 bit; idx never exceeds NIB-1.
- Arithmetic is unsigned. Overflow is reported only through cout; there is no saturation.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, idx=0, carry=0, operand and shadow regs=0, sum=0, cout=0, out_valid=0.
  - in_ready reads 1 while in IDLE, but nothing is captured while rst_n is low.
  - Release is sampled on the next rising edge.
- Acceptance edge E0 → nibble k is stored at edge E(k+1).
- out_valid rises after edge E(NIB): latency NIB cycles (4 for WIDTH=16; 1 for WIDTH=4).
- Result handshake edge with out_ready=1 → out_valid=0 and in_ready=1 in the following cycle.
- Minimum spacing between acceptances: NIB+2 cycles.
- Backpressure: out_valid, sum and cout are held indefinitely while out_ready=0.
  - If out_ready was already high when DONE is entered, the handshake completes on the first DONE edge.
- in_valid dropping during RUN has no effect; operands are already latched.
- Asserting rst_n mid-RUN or mid-DONE aborts the operation immediately, with no partial output.
  - The next accepted operation computes from a clean carry.

## Test plan
- Reset: hold rst_n=0 with random inputs → out_valid=0, sum=0x0000, cout=0. After release, in_ready=1.
- WIDTH=16, a=0x1234, b=0x4321, cin=0, out_ready=1 → out_valid exactly 4 cycles after acceptance, sum=0x5555, cout=0. in_ready=0 during RUN/DONE.
- Full ripple: a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1.
- Max overflow: a=0xFFFF, b=0xFFFF, cin=1 → sum=0xFFFF, cout=1.
- Backpressure: out_ready=0 for 10 cycles after DONE with in_valid=1 and new operands presented → out_valid stays 1 and sum stays constant. The new operands are not captured until one cycle after out_ready=1 completes the handshake.
- Reset mid-RUN: assert rst_n=0 two cycles after accepting a=0x8000, b=0x8000 → out_valid=0 and sum=0 immediately.
  - Then a=0x0001, b=0x0001, cin=0 → sum=0x0002, cout=0.
  - Then 1000 random back-to-back ops with out_ready=1 → acceptances every 6 cycles, each result equal to {cout,sum}=a+b+cin. Repeat the random run with WIDTH=4 (latency 1, spacing 3).

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Sequential WIDTH-bit adder: one nibble per cycle through a single 4-bit ripple adder,
// with valid/ready handshakes on both the operand and the result side.

module ripple_adder_4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic c1_s;
   logic c2_s;
   logic c3_s;

   assign sum[0] = a[0] ^ b[0] ^ cin;
   assign c1_s   = (a[0] & b[0]) | (cin & (a[0] ^ b[0]));
   assign sum[1] = a[1] ^ b[1] ^ c1_s;
   assign c2_s   = (a[1] & b[1]) | (c1_s & (a[1] ^ b[1]));
   assign sum[2] = a[2] ^ b[2] ^ c2_s;
   assign c3_s   = (a[2] & b[2]) | (c2_s & (a[2] ^ b[2]));
   assign sum[3] = a[3] ^ b[3] ^ c3_s;
   assign cout   = (a[3] & b[3]) | (c3_s & (a[3] ^ b[3]));

endmodule

module nibble_serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int NIB  = WIDTH / 4;
   localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic              carry_q, carry_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [WIDTH-1:0]  shadow_q, shadow_d;
   logic [WIDTH-1:0]  sum_q, sum_d;
   logic              cout_q, cout_d;

   logic [WIDTH-1:0]  a_shift_s;
   logic [WIDTH-1:0]  b_shift_s;
   logic [3:0]        nib_a_s;
   logic [3:0]        nib_b_s;
   logic [3:0]        add_sum_s;
   logic              add_cout_s;
   logic              last_s;

   // Current nibble selected by shifting the operand registers down by 4*idx
   assign a_shift_s = a_q >> {idx_q, 2'b00};
   assign b_shift_s = b_q >> {idx_q, 2'b00};
   assign nib_a_s   = a_shift_s[3:0];
   assign nib_b_s   = b_shift_s[3:0];
   assign last_s    = (idx_q == IDXW'(NIB - 1));

   ripple_adder_4 u_adder (
      .a    (nib_a_s),
      .b    (nib_b_s),
      .cin  (carry_q),
      .sum  (add_sum_s),
      .cout (add_cout_s)
   );

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;

   // Next-state and datapath update
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      a_d      = a_q;
      b_d      = b_q;
      shadow_d = shadow_q;
      sum_d    = sum_q;
      cout_d   = cout_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               idx_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            carry_d = add_cout_s;
            for (int i = 0; i < NIB; i++) begin
               if (idx_q == IDXW'(i)) begin
                  shadow_d[4*i +: 4] = add_sum_s;
               end else begin
                  shadow_d[4*i +: 4] = shadow_q[4*i +: 4];
               end
            end
            // The result register takes the shadow including the nibble written this edge
            if (last_s) begin
               sum_d   = shadow_d;
               cout_d  = add_cout_s;
               state_d = DONE;
            end else begin
               idx_d   = idx_q + IDXW'(1);
               state_d = RUN;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         shadow_q <= '0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         a_q      <= a_d;
         b_q      <= b_d;
         shadow_q <= shadow_d;
         sum_q    <= sum_d;
         cout_q   <= cout_d;
      end
   end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed cases on a 16-bit instance,
// random back-to-back runs on 16-bit and 4-bit instances, scoreboard-checked results.

module tb_nibble_serial_adder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        iv16 = 1'b0, ir16, ov16, ordy16 = 1'b1, cin16 = 1'b0, cout16;
   logic [15:0] a16 = 16'h0, b16 = 16'h0, sum16;
   logic        iv4 = 1'b0, ir4, ov4, ordy4 = 1'b1, cin4 = 1'b0, cout4;
   logic [3:0]  a4 = 4'h0, b4 = 4'h0, sum4;

   logic [16:0] sb16[$];
   logic [4:0]  sb4[$];
   logic [16:0] e16;
   logic [4:0]  e4;
   logic        ov16_prev = 1'b0, ov4_prev = 1'b0;
   int          cyc = 0, acc16 = 0, acc4 = 0;
   int          n_vec = 0, n_err = 0;

   nibble_serial_adder #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
      .cin(cin16), .out_valid(ov16), .out_ready(ordy16), .sum(sum16), .cout(cout16));

   nibble_serial_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
      .cin(cin4), .out_valid(ov4), .out_ready(ordy4), .sum(sum4), .cout(cout4));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Result monitors: latency on out_valid rise, scoreboard pop on handshake
   always @(negedge clk) begin
      if (rst_n) begin
         if (ov16 && !ov16_prev) check_eq("lat16", 32'(cyc - acc16), 32'd4);
         if (ov16 && ordy16) begin
            if (sb16.size() == 0) check_eq("extra16", 32'(ov16), 32'd0);
            else begin
               e16 = sb16.pop_front();
               check_eq("res16", 32'({cout16, sum16}), 32'(e16));
            end
         end
         if (ov4 && !ov4_prev) check_eq("lat4", 32'(cyc - acc4), 32'd1);
         if (ov4 && ordy4) begin
            if (sb4.size() == 0) check_eq("extra4", 32'(ov4), 32'd0);
            else begin
               e4 = sb4.pop_front();
               check_eq("res4", 32'({cout4, sum4}), 32'(e4));
            end
         end
      end
      ov16_prev = ov16;
      ov4_prev  = ov4;
   end

   task automatic send16(input logic [15:0] ta, input logic [15:0] tb, input logic tc);
      int n = 0;
      do begin @(negedge clk); n++; end while (!ir16 && n < 200);
      if (!ir16) begin check_eq("rdy16_timeout", 32'(ir16), 32'd1); return; end
      a16 = ta; b16 = tb; cin16 = tc; iv16 = 1'b1;
      sb16.push_back({1'b0, ta} + {1'b0, tb} + {16'h0, tc});
      @(posedge clk); #1;
      iv16 = 1'b0;
      acc16 = cyc;
      check_eq("accept16", 32'(ir16), 32'd0);
   endtask

   task automatic send4(input logic [3:0] ta, input logic [3:0] tb, input logic tc);
      int n = 0;
      do begin @(negedge clk); n++; end while (!ir4 && n < 200);
      if (!ir4) begin check_eq("rdy4_timeout", 32'(ir4), 32'd1); return; end
      a4 = ta; b4 = tb; cin4 = tc; iv4 = 1'b1;
      sb4.push_back({1'b0, ta} + {1'b0, tb} + {4'h0, tc});
      @(posedge clk); #1;
      iv4 = 1'b0;
      acc4 = cyc;
      check_eq("accept4", 32'(ir4), 32'd0);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((sb16.size() != 0 || sb4.size() != 0) && n < 200) begin @(negedge clk); n++; end
      check_eq(tag, 32'(sb16.size() + sb4.size()), 32'd0);
   endtask

   initial begin
      logic [15:0] held;
      int prev, n;

      // Reset held with random inputs presented
      iv16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'b1;
      iv4  = 1'b1; a4  = 4'($urandom);  b4  = 4'($urandom);  cin4  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("rst_ov16", 32'(ov16), 32'd0);
         check_eq("rst_sum16", 32'(sum16), 32'h0);
         check_eq("rst_cout16", 32'(cout16), 32'd0);
         check_eq("rst_ov4", 32'(ov4), 32'd0);
      end
      iv16 = 1'b0; iv4 = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_eq("rdy_after_rst", 32'(ir16), 32'd1);

      // Directed: basic add, in_ready low through RUN and DONE
      send16(16'h1234, 16'h4321, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("busy16", 32'(ir16), 32'd0);
      end
      drain("drain_basic");
      send16(16'hFFFF, 16'h0000, 1'b1);
      drain("drain_ripple");
      send16(16'hFFFF, 16'hFFFF, 1'b1);
      drain("drain_max");

      // Backpressure with new operands waiting
      ordy16 = 1'b0;
      send16(16'hA5A5, 16'h0F0F, 1'b1);
      n = 0;
      do begin @(negedge clk); n++; end while (!ov16 && n < 50);
      check_eq("bp_done", 32'(ov16), 32'd1);
      held = sum16;
      a16 = 16'h7777; b16 = 16'h1111; cin16 = 1'b0; iv16 = 1'b1;
      sb16.push_back({1'b0, a16} + {1'b0, b16});
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_eq("bp_ov", 32'(ov16), 32'd1);
         check_eq("bp_sum", 32'(sum16), 32'(held));
         check_eq("bp_rdy", 32'(ir16), 32'd0);
      end
      @(posedge clk); #1;
      ordy16 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_eq("bp_not_yet", 32'(ir16), 32'd1);
      @(posedge clk); #1;
      acc16 = cyc;
      iv16 = 1'b0;
      check_eq("bp_captured", 32'(ir16), 32'd0);
      drain("drain_bp");

      // Reset two cycles into RUN
      send16(16'h8000, 16'h8000, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      sb16.delete();
      #1;
      check_eq("midrst_ov", 32'(ov16), 32'd0);
      check_eq("midrst_sum", 32'(sum16), 32'h0);
      check_eq("midrst_cout", 32'(cout16), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      send16(16'h0001, 16'h0001, 1'b0);
      drain("drain_post_rst");

      // Random back-to-back, 16-bit
      send16(16'($urandom), 16'($urandom), 1'($urandom));
      prev = acc16;
      for (int i = 1; i < 1000; i++) begin
         send16(16'($urandom), 16'($urandom), 1'($urandom));
         check_eq("gap16", 32'(acc16 - prev), 32'd6);
         prev = acc16;
      end
      drain("drain_rand16");

      // Random back-to-back, 4-bit
      send4(4'($urandom), 4'($urandom), 1'($urandom));
      prev = acc4;
      for (int i = 1; i < 1000; i++) begin
         send4(4'($urandom), 4'($urandom), 1'($urandom));
         check_eq("gap4", 32'(acc4 - prev), 32'd3);
         prev = acc4;
      end
      drain("drain_rand4");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
